regfile_scoreboard: RTL and testbench

Parametrised multi-read, dual-write register file for the 5-stage core and its variants. Writes land on the rising edge. Reads are combinational, with same-cycle write-to-read bypass. A per-register pending scoreboard supports hazard detection. After reset, a clear sequencer zeroes the array one entry per cycle.

---
 rtl/regfile_scoreboard.sv | 118 +++++++++++
 tb/tb_regfile_scoreboard.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Multi-read, dual-write register file with same-cycle write bypass, a per-register
// pending scoreboard for hazard detection, and a post-reset clear sequencer.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                ready
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           r_state;
  logic [AW-1:0]    r_clrIdx;
  logic             r_ready;
  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] r_pending;

  logic w_isRun;
  logic w_run;
  logic w_wr0Ok;
  logic w_wr1Ok;
  logic w_issOk;

  // Addresses that name a real, writable register (excludes hardwired x0).
  function automatic logic addrOk(input logic [AW-1:0] a);
    logic [31:0] aExt;
    aExt = 32'(a);
    return (aExt < 32'(NREGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_isRun = (r_state == RUN);
  assign w_run   = rst && w_isRun;
  assign w_wr0Ok = w_run && wr0_en && addrOk(wr0_addr);
  assign w_wr1Ok = w_run && wr1_en && addrOk(wr1_addr);
  assign w_issOk = w_run && iss_en && addrOk(iss_addr);
  assign ready   = r_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= CLEAR;
      r_clrIdx <= '0;
      r_ready  <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_clrIdx <= r_clrIdx + 1'b1;
      if (r_clrIdx == AW'(NREGS - 1)) begin
        r_state <= RUN;
        r_ready <= 1'b1;
      end
    end
  end

  // Port 1 is checked first so it wins a same-address collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (r_state == CLEAR) begin
        if (r_clrIdx == AW'(i)) r_mem[i] <= '0;
      end else if (w_wr1Ok && (wr1_addr == AW'(i))) begin
        r_mem[i] <= wr1_data;
      end else if (w_wr0Ok && (wr0_addr == AW'(i))) begin
        r_mem[i] <= wr0_data;
      end
    end
  end

  // A new issue outranks a retiring write: the newer producer is still in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_issOk && (iss_addr == AW'(i))) begin
          r_pending[i] <= 1'b1;
        end else if ((w_wr0Ok && (wr0_addr == AW'(i))) ||
                     (w_wr1Ok && (wr1_addr == AW'(i)))) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (w_isRun && addrOk(rd_addr[k*AW +: AW])) begin
        if (w_wr1Ok && (wr1_addr == rd_addr[k*AW +: AW])) begin
          rd_data[k*XLEN +: XLEN] = wr1_data;
        end else if (w_wr0Ok && (wr0_addr == rd_addr[k*AW +: AW])) begin
          rd_data[k*XLEN +: XLEN] = wr0_data;
        end else begin
          for (int i = 0; i < NREGS; i++) begin
            if (rd_addr[k*AW +: AW] == AW'(i)) begin
              rd_data[k*XLEN +: XLEN] = r_mem[i];
              rd_busy[k]              = r_pending[i];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus pushes hand-computed expectations
// into a queue, and a negedge monitor pops and compares them against the outputs.
module tb_regfile_scoreboard;

   typedef struct {
      int          dutSel;
      int          kind;
      int          port;
      logic [31:0] exp;
      string       name;
   } exp_t;

   localparam int KIND_DATA  = 0;
   localparam int KIND_BUSY  = 1;
   localparam int KIND_READY = 2;
   localparam int WATCHDOG_CYCLES = 2000;

   logic clk = 1'b0;
   logic rst;

   logic [9:0]   aRdAddr;
   logic [63:0]  aRdData;
   logic [1:0]   aRdBusy;
   logic         aWr0En, aWr1En, aIssEn, aReady;
   logic [4:0]   aWr0Addr, aWr1Addr, aIssAddr;
   logic [31:0]  aWr0Data, aWr1Data;

   logic [19:0]  bRdAddr;
   logic [127:0] bRdData;
   logic [3:0]   bRdBusy;
   logic         bWr0En, bWr1En, bIssEn, bReady;
   logic [4:0]   bWr0Addr, bWr1Addr, bIssAddr;
   logic [31:0]  bWr0Data, bWr1Data;

   exp_t scbQ[$];
   int   compared   = 0;
   int   mismatched = 0;
   bit   testDone   = 1'b0;

   // Free-running clock with a 10-time-unit period.
   always #5 clk = ~clk;

   regfile_scoreboard #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .ZERO_REG(1)) dutA (
      .clk(clk), .rst(rst),
      .rd_addr(aRdAddr), .rd_data(aRdData), .rd_busy(aRdBusy),
      .wr0_en(aWr0En), .wr0_addr(aWr0Addr), .wr0_data(aWr0Data),
      .wr1_en(aWr1En), .wr1_addr(aWr1Addr), .wr1_data(aWr1Data),
      .iss_en(aIssEn), .iss_addr(aIssAddr), .ready(aReady)
   );

   regfile_scoreboard #(.XLEN(32), .NREGS(24), .AW(5), .NRD(4), .ZERO_REG(0)) dutB (
      .clk(clk), .rst(rst),
      .rd_addr(bRdAddr), .rd_data(bRdData), .rd_busy(bRdBusy),
      .wr0_en(bWr0En), .wr0_addr(bWr0Addr), .wr0_data(bWr0Data),
      .wr1_en(bWr1En), .wr1_addr(bWr1Addr), .wr1_data(bWr1Data),
      .iss_en(bIssEn), .iss_addr(bIssAddr), .ready(bReady)
   );

   // Monitor: every expectation queued during a cycle is checked at its falling edge.
   always @(negedge clk) begin
      while (scbQ.size() > 0) begin
         exp_t        e;
         logic [31:0] act;
         e = scbQ.pop_front();
         case (e.kind)
            KIND_DATA: act = (e.dutSel == 0) ? aRdData[e.port*32 +: 32] : bRdData[e.port*32 +: 32];
            KIND_BUSY: act = {31'b0, ((e.dutSel == 0) ? aRdBusy[e.port] : bRdBusy[e.port])};
            default:   act = {31'b0, ((e.dutSel == 0) ? aReady : bReady)};
         endcase
         compared++;
         if (act !== e.exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", e.name, act, e.exp);
         end
      end
   end

   // Watchdog: if the directed sequence has not completed within a bounded number
   // of clock edges, the wait has expired and the run is reported as a failure.
   initial begin
      repeat (WATCHDOG_CYCLES) @(posedge clk);
      compared++;
      if (!testDone) begin
         mismatched++;
         $display("[TB] FAIL watchdog: test did not finish within %0d cycles", WATCHDOG_CYCLES);
         $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
         $finish;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input int dutSel, input int kind, input int port,
                              input logic [31:0] exp, input string name);
      exp_t e;
      e.dutSel = dutSel;
      e.kind   = kind;
      e.port   = port;
      e.exp    = exp;
      e.name   = name;
      scbQ.push_back(e);
   endtask

   task automatic checkResetState();
      compared++;
      if ((aReady !== 1'b0) || (aRdBusy !== '0) || (aRdData !== '0) ||
          (bReady !== 1'b0) || (bRdBusy !== '0) || (bRdData !== '0)) begin
         mismatched++;
         $display("[TB] FAIL reset state: aReady=%b aBusy=%b aData=0x%h bReady=%b bBusy=%b bData=0x%h",
                  aReady, aRdBusy, aRdData, bReady, bRdBusy, bRdData);
      end
   endtask

   task automatic applyStimulus(input int w0En, input int w0A, input logic [31:0] w0D,
                                input int w1En, input int w1A, input logic [31:0] w1D,
                                input int iEn, input int iA, input int r0, input int r1);
      aWr0En   = (w0En != 0);
      aWr0Addr = 5'(w0A);
      aWr0Data = w0D;
      aWr1En   = (w1En != 0);
      aWr1Addr = 5'(w1A);
      aWr1Data = w1D;
      aIssEn   = (iEn != 0);
      aIssAddr = 5'(iA);
      aRdAddr  = {5'(r1), 5'(r0)};
   endtask

   task automatic readAllZeroA(input string tag);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2*i, 2*i + 1);
         checkOutput(0, KIND_DATA, 0, 0, {tag, " data even"});
         checkOutput(0, KIND_DATA, 1, 0, {tag, " data odd"});
         checkOutput(0, KIND_BUSY, 0, 0, {tag, " busy even"});
         checkOutput(0, KIND_BUSY, 1, 0, {tag, " busy odd"});
         tick();
      end
   endtask

   // Main directed sequence covering every item of the test plan.
   initial begin
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      bWr0En = 1'b0; bWr0Addr = 5'd0; bWr0Data = 32'h0;
      bWr1En = 1'b0; bWr1Addr = 5'd0; bWr1Data = 32'h0;
      bIssEn = 1'b0; bIssAddr = 5'd0; bRdAddr  = 20'h0;
      tick();
      tick();
      checkResetState();

      rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         checkOutput(0, KIND_READY, 0, 0, "clear ready low");
         checkOutput(0, KIND_DATA, 0, 0, "clear data zero");
         checkOutput(0, KIND_BUSY, 1, 0, "clear busy zero");
         tick();
      end
      checkOutput(0, KIND_READY, 0, 1, "ready after 32 cycles");
      checkOutput(1, KIND_READY, 0, 1, "B ready after clear");
      tick();
      readAllZeroA("post-clear");

      applyStimulus(1, 5, 32'hDEADBEEF, 1, 7, 32'h12345678, 0, 0, 5, 7);
      checkOutput(0, KIND_DATA, 0, 32'hDEADBEEF, "bypass x5");
      checkOutput(0, KIND_DATA, 1, 32'h12345678, "bypass x7");
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
      checkOutput(0, KIND_DATA, 0, 32'hDEADBEEF, "array x5");
      checkOutput(0, KIND_DATA, 1, 32'h12345678, "array x7");
      tick();
      applyStimulus(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 5);
      checkOutput(0, KIND_DATA, 0, 0, "x0 no bypass");
      checkOutput(0, KIND_DATA, 1, 32'hDEADBEEF, "x5 unaffected");
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput(0, KIND_DATA, 0, 0, "x0 stays zero");
      tick();

      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 3, 3);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
      checkOutput(0, KIND_BUSY, 0, 1, "x3 pending");
      tick();
      applyStimulus(1, 3, 32'hAAAA0000, 1, 3, 32'h5555FFFF, 0, 0, 3, 3);
      checkOutput(0, KIND_DATA, 0, 32'h5555FFFF, "collision bypass p0");
      checkOutput(0, KIND_DATA, 1, 32'h5555FFFF, "collision bypass p1");
      checkOutput(0, KIND_BUSY, 0, 0, "collision busy p0");
      checkOutput(0, KIND_BUSY, 1, 0, "collision busy p1");
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
      checkOutput(0, KIND_DATA, 0, 32'h5555FFFF, "collision array");
      checkOutput(0, KIND_BUSY, 1, 0, "x3 cleared");
      tick();

      applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
      checkOutput(0, KIND_BUSY, 0, 0, "x9 before issue edge");
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
      checkOutput(0, KIND_BUSY, 0, 1, "x9 pending");
      tick();
      checkOutput(0, KIND_BUSY, 1, 1, "x9 still pending");
      tick();
      applyStimulus(1, 9, 32'h42, 0, 0, 0, 0, 0, 9, 9);
      checkOutput(0, KIND_BUSY, 0, 0, "x9 write-cycle busy");
      checkOutput(0, KIND_DATA, 0, 32'h42, "x9 write bypass");
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
      checkOutput(0, KIND_BUSY, 0, 0, "x9 cleared by wr0");
      checkOutput(0, KIND_DATA, 1, 32'h42, "x9 array");
      tick();
      applyStimulus(1, 9, 32'h43, 0, 0, 0, 1, 9, 9, 9);
      checkOutput(0, KIND_BUSY, 0, 0, "issue+write busy bypassed");
      checkOutput(0, KIND_DATA, 0, 32'h43, "issue+write data");
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
      checkOutput(0, KIND_BUSY, 0, 1, "issue wins over write");
      checkOutput(0, KIND_DATA, 1, 32'h43, "x9 array after issue+write");
      tick();
      applyStimulus(0, 0, 0, 1, 9, 32'h44, 0, 0, 9, 9);
      checkOutput(0, KIND_BUSY, 1, 0, "x9 wr1 busy bypassed");
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
      checkOutput(0, KIND_BUSY, 0, 0, "x9 cleared by wr1");
      checkOutput(0, KIND_DATA, 0, 32'h44, "x9 wr1 array");
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput(0, KIND_BUSY, 0, 0, "x0 issue ignored");
      tick();

      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 9);
      tick();
      rst = 1'b1;
      checkOutput(0, KIND_READY, 0, 0, "ready drops after reset");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, i + 31, 32'hA5A5A5A5, 1, i + 10, 32'h5A5A5A5A, 1, i + 20, 5, 9);
         checkOutput(0, KIND_READY, 0, 0, "first clear ready low");
         checkOutput(0, KIND_DATA, 0, 0, "clear masks data");
         checkOutput(0, KIND_BUSY, 1, 0, "clear masks busy");
         tick();
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1, i + 31, 32'hFFFF0000, 1, 31 - i, 32'h0000FFFF, 1, i, 3, 9);
         checkOutput(0, KIND_READY, 0, 0, "restarted clear ready low");
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput(0, KIND_READY, 0, 1, "ready 32 cycles after pulse");
      tick();
      readAllZeroA("gated");

      bWr0En = 1'b1; bWr0Addr = 5'd0;  bWr0Data = 32'h1;
      bWr1En = 1'b1; bWr1Addr = 5'd30; bWr1Data = 32'hBAD0BAD0;
      bRdAddr = {5'd6, 5'd24, 5'd30, 5'd0};
      checkOutput(1, KIND_DATA, 0, 32'h1, "B x0 bypass");
      checkOutput(1, KIND_DATA, 1, 0, "B addr30 no bypass");
      checkOutput(1, KIND_DATA, 2, 0, "B addr24 reads zero");
      tick();
      bWr0Addr = 5'd1;  bWr0Data = 32'h11;
      bWr1Addr = 5'd23; bWr1Data = 32'h2323;
      bIssEn = 1'b1; bIssAddr = 5'd0;
      bRdAddr = {5'd14, 5'd6, 5'd30, 5'd0};
      checkOutput(1, KIND_DATA, 0, 32'h1, "B x0 writable");
      checkOutput(1, KIND_DATA, 1, 0, "B addr30 reads zero");
      checkOutput(1, KIND_BUSY, 1, 0, "B addr30 busy zero");
      checkOutput(1, KIND_DATA, 2, 0, "B no alias x6");
      checkOutput(1, KIND_DATA, 3, 0, "B no alias x14");
      tick();
      bWr0Addr = 5'd2; bWr0Data = 32'h22;
      bWr1En = 1'b0;
      bIssAddr = 5'd30;
      bRdAddr = {5'd23, 5'd2, 5'd1, 5'd0};
      checkOutput(1, KIND_BUSY, 0, 1, "B x0 pending");
      checkOutput(1, KIND_DATA, 1, 32'h11, "B x1 array");
      checkOutput(1, KIND_DATA, 2, 32'h22, "B x2 bypass");
      checkOutput(1, KIND_DATA, 3, 32'h2323, "B x23 array");
      tick();
      bWr0En = 1'b0; bIssEn = 1'b0;
      checkOutput(1, KIND_DATA, 0, 32'h1, "B four ports p0");
      checkOutput(1, KIND_DATA, 1, 32'h11, "B four ports p1");
      checkOutput(1, KIND_DATA, 2, 32'h22, "B four ports p2");
      checkOutput(1, KIND_DATA, 3, 32'h2323, "B four ports p3");
      tick();
      bRdAddr = {5'd0, 5'd0, 5'd0, 5'd30};
      checkOutput(1, KIND_BUSY, 0, 0, "B issue to 30 ignored");
      checkOutput(1, KIND_DATA, 0, 0, "B addr30 still zero");
      tick();
      tick();

      testDone = 1'b1;
      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
